// File: rtl/adpll_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_cfg_pkg
//  Description : Shared widths, table depth and FSM state encoding for the
//                ADPLL configuration writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adpll_cfg_pkg;

    localparam int unsigned c_idx_w     = 3;
    localparam int unsigned c_val_w     = 5;
    localparam int unsigned c_tbl_depth = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SETUP = 3'd2,
        ST_PGM   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/adpll_cfg_prienc.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_cfg_prienc
//  Description : Lowest-set-bit finder over (vector AND mask), with valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module adpll_cfg_prienc
    import adpll_cfg_pkg::*;
(
    input  logic [c_tbl_depth-1:0] i_vec,
    input  logic [c_tbl_depth-1:0] i_mask,
    output logic [c_idx_w-1:0]     o_idx,
    output logic                   o_valid
);

    logic [c_tbl_depth-1:0] w_hits;

    assign w_hits  = i_vec & i_mask;
    assign o_valid = |w_hits;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = c_tbl_depth - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                o_idx = i[c_idx_w-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adpll_cfg_writer.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_cfg_writer
//  Description : Shadow-table driven ADPLL programming sequencer.
//                Optional macro ADPLL_CFG_AUTOCLR_EN adds a clr phase at start.
//  Revision    : 1.0 - initial release
// ============================================================================
module adpll_cfg_writer
    import adpll_cfg_pkg::*;
#(
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PGM_CYC   = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [c_idx_w-1:0]     wr_addr,
    input  logic [c_val_w-1:0]     wr_data,
    input  logic [c_tbl_depth-1:0] wr_mask,
    input  logic                   mask_ld,
    input  logic                   start,
    input  logic                   abort,
    output logic                   clr,
    output logic                   pgm,
    output logic [c_idx_w-1:0]     param_sel,
    output logic [c_val_w-1:0]     pgm_value,
    output logic                   busy,
    output logic                   done,
    output logic                   wr_err
);

    // A zero-length phase would be meaningless; it is stretched to one cycle.
    localparam int unsigned c_clr_eff   = (CLR_CYC   == 0) ? 1 : CLR_CYC;
    localparam int unsigned c_setup_eff = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
    localparam int unsigned c_pgm_eff   = (PGM_CYC   == 0) ? 1 : PGM_CYC;
    localparam int unsigned c_hold_eff  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;
    localparam int unsigned c_max_a     = (c_clr_eff > c_setup_eff) ? c_clr_eff : c_setup_eff;
    localparam int unsigned c_max_b     = (c_pgm_eff > c_hold_eff) ? c_pgm_eff : c_hold_eff;
    localparam int unsigned c_cnt_max   = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int unsigned c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(c_setup_eff - 1);
    localparam logic [c_cnt_w-1:0] c_pgm_last   = c_cnt_w'(c_pgm_eff - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(c_hold_eff - 1);
`ifdef ADPLL_CFG_AUTOCLR_EN
    localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(c_clr_eff - 1);
`endif

    cfg_state_e             r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
    logic [c_tbl_depth-1:0] r_above, w_above_nxt;
    logic [c_idx_w-1:0]     r_sel, w_sel_nxt;
    logic [c_val_w-1:0]     r_val, w_val_nxt;
    logic [c_tbl_depth-1:0] r_mask;
    logic [c_val_w-1:0]     r_table [c_tbl_depth];
    logic                   r_pgm, r_busy, r_done, r_wr_err;
    logic [c_idx_w-1:0]     w_pe_idx;
    logic                   w_pe_valid;

    adpll_cfg_prienc u_prienc (
        .i_vec   (r_mask),
        .i_mask  (r_above),
        .o_idx   (w_pe_idx),
        .o_valid (w_pe_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_above_nxt = r_above;
        w_sel_nxt   = r_sel;
        w_val_nxt   = r_val;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_above_nxt = '1;
                    w_cnt_nxt   = '0;
`ifdef ADPLL_CFG_AUTOCLR_EN
                    w_state_nxt = ST_CLR;
`else
                    w_state_nxt = ST_NEXT;
`endif
                end
            end
`ifdef ADPLL_CFG_AUTOCLR_EN
            ST_CLR: begin
                if (r_cnt == c_clr_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            ST_NEXT: begin
                if (w_pe_valid) begin
                    w_sel_nxt   = w_pe_idx;
                    w_val_nxt   = r_table[w_pe_idx];
                    // Only indices strictly above this one remain eligible.
                    w_above_nxt = ({c_tbl_depth{1'b1}} << 1) << w_pe_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PGM;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PGM: begin
                if (r_cnt == c_pgm_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // Abort beats everything, including a start arriving in IDLE.
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_above  <= '0;
            r_sel    <= '0;
            r_val    <= '0;
            r_mask   <= '0;
            r_pgm    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_above  <= w_above_nxt;
            r_sel    <= w_sel_nxt;
            r_val    <= w_val_nxt;
            r_pgm    <= (w_state_nxt == ST_PGM);
            r_busy   <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done   <= (w_state_nxt == ST_DONE);
            r_wr_err <= (wr_en || mask_ld) && r_busy;
            if (mask_ld && !r_busy) begin
                r_mask <= wr_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_tbl_depth; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en && !r_busy) begin
            r_table[wr_addr] <= wr_data;
        end
    end

`ifdef ADPLL_CFG_AUTOCLR_EN
    logic r_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr <= 1'b0;
        end else begin
            r_clr <= (w_state_nxt == ST_CLR);
        end
    end

    assign clr = r_clr;
`else
    assign clr = 1'b0;
`endif

    assign pgm       = r_pgm;
    assign param_sel = r_sel;
    assign pgm_value = r_val;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_adpll_cfg_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adpll_cfg_writer
//  Description : Directed self-checking bench for adpll_cfg_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adpll_cfg_writer;

`ifdef ADPLL_CFG_AUTOCLR_EN
    localparam int c_clr_exp = 2;
`else
    localparam int c_clr_exp = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [7:0] wr_mask = '0;
    logic       mask_ld = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clr, pgm, busy, done, wr_err;
    logic [2:0] param_sel;
    logic [4:0] pgm_value;

    int n_tests = 0;
    int n_fail  = 0;

    // Sequence observation statistics (filled by the monitor below)
    bit  mon_en = 1'b0;
    int  n_clr, n_done, n_done_busy, n_pulse, n_unstable;
    int  p_sel [8];
    int  p_val [8];
    int  p_len [8];
    bit  prev_pgm;
    int  first_busy, cyc_done;

    adpll_cfg_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .mask_ld   (mask_ld),
        .start     (start),
        .abort     (abort),
        .clr       (clr),
        .pgm       (pgm),
        .param_sel (param_sel),
        .pgm_value (pgm_value),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (clr) n_clr++;
            if (done) begin
                n_done++;
                if (busy) n_done_busy++;
            end
            if (pgm) begin
                if (!prev_pgm) begin
                    if (n_pulse < 8) begin
                        p_sel[n_pulse] = int'(param_sel);
                        p_val[n_pulse] = int'(pgm_value);
                        p_len[n_pulse] = 0;
                    end
                    n_pulse++;
                end
                if (n_pulse >= 1 && n_pulse <= 8) begin
                    p_len[n_pulse-1]++;
                    if (int'(param_sel) != p_sel[n_pulse-1] || int'(pgm_value) != p_val[n_pulse-1])
                        n_unstable++;
                end
            end else if (prev_pgm && busy && n_pulse >= 1 && n_pulse <= 8) begin
                if (int'(param_sel) != p_sel[n_pulse-1] || int'(pgm_value) != p_val[n_pulse-1])
                    n_unstable++;
            end
            prev_pgm = pgm;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_stats();
        n_clr = 0; n_done = 0; n_done_busy = 0; n_pulse = 0; n_unstable = 0;
        prev_pgm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p_sel[i] = -1; p_val[i] = -1; p_len[i] = 0;
        end
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_mask(input logic [7:0] m);
        mask_ld = 1'b1; wr_mask = m;
        tick();
        mask_ld = 1'b0;
    endtask

    // Pulse start, optionally pulse start again at cycle restart_at, and
    // observe until a few cycles past done (bounded).
    task automatic run_seq(input int restart_at);
        clear_stats();
        first_busy = 0;
        cyc_done = 0;
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (i == 1) first_busy = int'(busy);
            if (done && cyc_done == 0) cyc_done = i;
            if (cyc_done != 0 && i >= cyc_done + 3 && i > restart_at) break;
            start = (i == restart_at);
            tick();
        end
        start = 1'b0;
        mon_en = 1'b0;
    endtask

    task automatic wait_pgm_sel(input logic [2:0] sel, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pgm && param_sel == sel) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic program_table();
        write_entry(3'd0, 5'd3);
        write_entry(3'd2, 5'd17);
        write_entry(3'd7, 5'd31);
        load_mask(8'h85);
    endtask

    initial begin : main
        bit found;
        int sum;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk_eq("rst_outs", {26'd0, clr, pgm, busy, done, wr_err, 1'b0}, 32'd0);
        chk_eq("rst_sel", param_sel, 0);
        chk_eq("rst_val", pgm_value, 0);

        // Abort beats a simultaneous start
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_eq("abort_vs_start_busy", busy, 0);

        // Three-entry sequence
        program_table();
        run_seq(0);
        chk_eq("seq_first_busy", first_busy, 1);
        chk_eq("seq_clr_cycles", n_clr, c_clr_exp);
        chk_eq("seq_pulses", n_pulse, 3);
        chk_eq("seq_sel0", p_sel[0], 0);
        chk_eq("seq_val0", p_val[0], 3);
        chk_eq("seq_sel1", p_sel[1], 2);
        chk_eq("seq_val1", p_val[1], 17);
        chk_eq("seq_sel2", p_sel[2], 7);
        chk_eq("seq_val2", p_val[2], 31);
        chk_eq("seq_len0", p_len[0], 2);
        chk_eq("seq_len1", p_len[1], 2);
        chk_eq("seq_len2", p_len[2], 2);
        chk_eq("seq_done", n_done, 1);
        chk_eq("seq_done_busy", n_done_busy, 0);
        chk_eq("seq_stable", n_unstable, 0);

        // Empty mask: clr only, then done
        load_mask(8'h00);
        run_seq(0);
        chk_eq("m0_clr", n_clr, c_clr_exp);
        chk_eq("m0_pulses", n_pulse, 0);
        chk_eq("m0_done", n_done, 1);
        chk_eq("m0_latency", cyc_done, c_clr_exp + 2);

        // Write dropped while busy
        load_mask(8'h85);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pgm_sel(3'd2, found);
        chk_eq("wrerr_found_pgm", found, 1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd9;
        tick();
        wr_en = 1'b0;
        chk_eq("wrerr_pulse", wr_err, 1);
        tick();
        chk_eq("wrerr_one_cycle", wr_err, 0);
        for (int i = 0; i < 100 && busy; i++) tick();
        tick();
        run_seq(0);
        chk_eq("wrerr_readback", p_val[1], 17);

        // Abort during second entry
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pgm_sel(3'd2, found);
        chk_eq("abort_found_pgm", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("abort_pgm", pgm, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_clr", clr, 0);
        clear_stats();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        mon_en = 1'b0;
        chk_eq("abort_no_done", n_done, 0);
        run_seq(0);
        chk_eq("abort_replay_pulses", n_pulse, 3);
        chk_eq("abort_replay_sel0", p_sel[0], 0);

        // Reset during HOLD, with start and abort also asserted
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pgm_sel(3'd0, found);
        for (int i = 0; i < 10 && pgm; i++) tick();
        chk_eq("rst_in_hold_busy", busy, 1);
        rst_n = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        chk_eq("rst_mid_outs", {27'd0, clr, pgm, busy, done, wr_err}, 32'd0);
        chk_eq("rst_mid_sel_val", {param_sel, pgm_value}, 0);
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        tick();
        run_seq(0);
        chk_eq("rst_mask0_pulses", n_pulse, 0);
        chk_eq("rst_mask0_done", n_done, 1);
        load_mask(8'hFF);
        run_seq(0);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += p_val[i];
        chk_eq("rst_all_pulses", n_pulse, 8);
        chk_eq("rst_table_zero", sum, 0);
        chk_eq("rst_last_sel", p_sel[7], 7);

        // Second start while busy is ignored
        program_table();
        run_seq(5);
        chk_eq("restart_done", n_done, 1);
        chk_eq("restart_pulses", n_pulse, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/adpll_cfg_writer.md
ADPLL_CFG_WRITER -- requirements
Module: adpll_cfg_writer

Interface
REQ-001 SHALL have parameter CLR_CYC, default 2: cycles clr is held high.
REQ-002 SHALL have parameter SETUP_CYC, default 1: cycles param_sel/pgm_value are stable before pgm rises.
REQ-003 SHALL have parameter PGM_CYC, default 2: cycles pgm is held high.
REQ-004 SHALL have parameter HOLD_CYC, default 1: cycles param_sel/pgm_value are stable after pgm falls.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  shadow-table write strobe.
REQ-008 wr_addr  input  3  shadow-table entry index (= param_sel code).
REQ-009 wr_data  input  5  value for that entry.
REQ-010 wr_mask  input  8  per-entry enable mask; loaded when mask_ld is high.
REQ-011 mask_ld  input  1  mask load strobe.
REQ-012 start  input  1  begin a programming sequence.
REQ-013 abort  input  1  terminate a running sequence.
REQ-014 clr  output  1  ADPLL clear command.
REQ-015 pgm  output  1  ADPLL program strobe.
REQ-016 param_sel  output  3  ADPLL parameter selector.
REQ-017 pgm_value  output  5  ADPLL program value.
REQ-018 busy  output  1  sequence in progress.
REQ-019 done  output  1  one-cycle pulse at sequence completion.
REQ-020 wr_err  output  1  one-cycle pulse when a write or mask load is dropped.

Function
REQ-021 States SHALL be IDLE, CLR, SETUP, PGM, HOLD, NEXT, DONE; all outputs registered.
REQ-022 IDLE: start=1 -> CLR (macro defined) or NEXT (macro undefined); busy rises the cycle after start.
REQ-023 CLR: clr=1 for exactly CLR_CYC cycles, then NEXT.
REQ-024 NEXT: select lowest-indexed entry with mask bit set above the last programmed index; none -> DONE; found -> SETUP with param_sel/pgm_value driven from table.
REQ-025 SETUP lasts SETUP_CYC cycles, PGM lasts PGM_CYC cycles with pgm=1, HOLD lasts HOLD_CYC cycles, then NEXT.
REQ-026 param_sel/pgm_value SHALL not change during SETUP, PGM or HOLD of one entry.
REQ-027 DONE: done=1 for one cycle, busy=0 from that cycle, return to IDLE.
REQ-028 Entries scanned ascending 0..7 exactly once per sequence; no wrap-around past 7.
REQ-029 mask=0: sequence performs clr only (if enabled) and pulses done.
REQ-030 start while busy SHALL be ignored.
REQ-031 wr_en or mask_ld while busy SHALL be dropped, table unchanged, wr_err pulses next cycle.
REQ-032 abort while busy: next cycle pgm=0, clr=0, busy=0, state IDLE, no done pulse; abort wins over simultaneous start.
REQ-033 Phase counters SHALL be sized for the largest parameter; a parameter of 0 SHALL be treated as 1.

Reset
REQ-034 rst_n=0 at a clock edge: state IDLE; clr, pgm, busy, done, wr_err = 0; param_sel, pgm_value = 0; table and mask all zero.
REQ-035 Reset mid-sequence SHALL override abort and start, with no done pulse.

Configuration
REQ-036 Macro ADPLL_CFG_AUTOCLR_EN: defined -> CLR phase runs at every sequence start; undefined -> CLR state and its counter are absent and clr is tied 0.

Structure
REQ-037 Shared package adpll_cfg_pkg SHALL hold the state enum, parameter-index width (3), value width (5) and table depth (8).
REQ-038 Sub-module adpll_cfg_prienc (8-bit masked lowest-set-bit finder with valid flag) SHALL implement the NEXT-state search.

Verification
REQ-039 Write entries 0=5'd3, 2=5'd17, 7=5'd31, mask 8'h85, start -> clr high 2 cycles, then three pgm pulses of 2 cycles with (0,3),(2,17),(7,31), done once.
REQ-040 mask 8'h00, start -> clr 2 cycles (macro defined) or none (undefined), done within 3 cycles, pgm never high.
REQ-041 wr_en during PGM of entry 2 -> wr_err pulse, readback of next sequence shows original value.
REQ-042 abort during second entry PGM -> pgm low next cycle, busy low, no done; new start then replays all entries from index 0.
REQ-043 rst_n low during HOLD -> all outputs 0 next cycle, table cleared, following start with mask 0 yields done only.
REQ-044 Second start during busy -> exactly one sequence and one done pulse observed.
